uart_baud_gen: RTL and testbench

//  Runtime-programmable UART baud generator with a fractional prescaler and oversampling.
//  One shared prescaler drives three tick outputs:
//   - os_tick: oversample tick.
//   - tx_tick: TX bit-boundary tick.
//   - rx_tick: RX mid-bit sample tick, re-phased by an upstream start-edge pulse.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_frac_prescaler.sv | 87 ++++++++
 rtl/uart_baud_gen.sv | 65 ++++++
 tb/tb_uart_baud_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared defaults and divisor types for the UART baud generator
package uart_pkg;

  localparam int UART_DIV_W    = 16;
  localparam int UART_FRAC_W   = 4;
  localparam int UART_OVS      = 16;
  localparam int UART_DIV_RST  = 325;
  localparam int UART_FRAC_RST = 8;
  localparam int UART_DIV_MIN  = 2;

  typedef logic [UART_DIV_W-1:0]  div_int_t;
  typedef logic [UART_FRAC_W-1:0] div_frac_t;

endpackage

// File: rtl/uart_frac_prescaler.sv
// rtl/uart_frac_prescaler.sv - fractional prescaler producing os_tick, with shadowed divisor
module uart_frac_prescaler
  import uart_pkg::*;
#(
  parameter int DIV_W    = UART_DIV_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int DIV_RST  = UART_DIV_RST,
  parameter int FRAC_RST = UART_FRAC_RST
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_pend,
  output logic              os_tick
);

  localparam int CW = DIV_W + 1;
  localparam int AW = FRAC_W + 1;

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_int_act;
  logic [DIV_W-1:0]  div_int_sh;
  logic [FRAC_W-1:0] div_frac_act;
  logic [FRAC_W-1:0] div_frac_sh;
  logic [FRAC_W-1:0] acc;
  logic              carry;

  logic [DIV_W-1:0]  div_eff;
  logic [CW-1:0]     lim_m1;
  logic [AW-1:0]     acc_sum;
  logic              boundary;
  logic              apply;

  // Period length is the clamped integer divisor plus the carry left by the previous period.
  always_comb begin
    div_eff  = (div_int_act < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : div_int_act;
    lim_m1   = {1'b0, div_eff} + CW'(carry) - CW'(1);
    boundary = en && ({1'b0, cnt} == lim_m1);
    acc_sum  = {1'b0, acc} + {1'b0, div_frac_act};
    apply    = div_pend && (!en || boundary);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt          <= '0;
      acc          <= '0;
      carry        <= 1'b0;
      os_tick      <= 1'b0;
      div_pend     <= 1'b0;
      div_int_act  <= DIV_W'(DIV_RST);
      div_frac_act <= FRAC_W'(FRAC_RST);
      div_int_sh   <= DIV_W'(DIV_RST);
      div_frac_sh  <= FRAC_W'(FRAC_RST);
    end else begin
      if (!en) begin
        cnt     <= '0;
        acc     <= '0;
        carry   <= 1'b0;
        os_tick <= 1'b0;
      end else if (boundary) begin
        cnt            <= '0;
        {carry, acc}   <= acc_sum;
        os_tick        <= 1'b1;
      end else begin
        cnt     <= cnt + DIV_W'(1);
        os_tick <= 1'b0;
      end

      // A load landing on the apply edge is kept pending for the following boundary.
      if (apply) begin
        div_int_act  <= div_int_sh;
        div_frac_act <= div_frac_sh;
      end
      if (div_load) begin
        div_int_sh  <= div_int;
        div_frac_sh <= div_frac;
        div_pend    <= 1'b1;
      end else if (apply) begin
        div_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - UART baud generator: shared prescaler, TX/RX phase counters, tick decode
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W    = UART_DIV_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int OVS      = UART_OVS,
  parameter int DIV_RST  = UART_DIV_RST,
  parameter int FRAC_RST = UART_FRAC_RST
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_pend,
  input  logic              rx_sync,
  output logic              os_tick,
  output logic              tx_tick,
  output logic              rx_tick
);

  localparam int PH_W = $clog2(OVS);

  logic [PH_W-1:0] tx_ph;
  logic [PH_W-1:0] rx_ph;

  uart_frac_prescaler #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .DIV_RST  (DIV_RST),
    .FRAC_RST (FRAC_RST)
  ) u_prescaler (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .div_pend (div_pend),
    .os_tick  (os_tick)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || !en) begin
      tx_ph <= '0;
      rx_ph <= '0;
    end else begin
      if (os_tick) begin
        tx_ph <= (tx_ph == PH_W'(OVS-1)) ? '0 : tx_ph + PH_W'(1);
      end
      // Start-edge resync beats a coincident os_tick so the RX bit restarts cleanly.
      if (rx_sync) begin
        rx_ph <= '0;
      end else if (os_tick) begin
        rx_ph <= (rx_ph == PH_W'(OVS-1)) ? '0 : rx_ph + PH_W'(1);
      end
    end
  end

  assign tx_tick = os_tick && (tx_ph == PH_W'(OVS-1));
  assign rx_tick = os_tick && !rx_sync && (rx_ph == PH_W'(OVS/2-1));

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen
module tb_uart_baud_gen;
  import uart_pkg::*;

  logic      clk_in = 1'b0;
  logic      rst_in, en, div_load, rx_sync;
  logic      div_pend, os_tick, tx_tick, rx_tick;
  div_int_t  div_int;
  div_frac_t div_frac;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk_in = ~clk_in;

  uart_baud_gen dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .div_pend (div_pend),
    .rx_sync  (rx_sync),
    .os_tick  (os_tick),
    .tx_tick  (tx_tick),
    .rx_tick  (rx_tick)
  );

  typedef struct {
    int d;
    int f;
    int first_os;
    int span;
    int first_tx;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; strobes are single-cycle so they drop here.
  task automatic step();
    @(posedge clk_in);
    #1;
    div_load = 1'b0;
    rx_sync  = 1'b0;
    cyc++;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_div(input int d, input int f);
    en       = 1'b0;
    div_int  = div_int_t'(d);
    div_frac = div_frac_t'(f);
    div_load = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic wait_os(output int t);
    t = -1;
    for (int k = 0; k < 2000; k++) begin
      step();
      settle();
      if (os_tick) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    int n, t, t1, t17, ttx, dd, ff, next_t, rxc;
    logic exp_os, exp_tx, exp_rx;

    vecs[0] = '{d: 4,  f: 0,  first_os: 4,  span: 64,  first_tx: 64};
    vecs[1] = '{d: 4,  f: 8,  first_os: 4,  span: 72,  first_tx: 71};
    vecs[2] = '{d: 0,  f: 0,  first_os: 2,  span: 32,  first_tx: 32};
    vecs[3] = '{d: 1,  f: 5,  first_os: 2,  span: 37,  first_tx: 36};
    vecs[4] = '{d: 10, f: 15, first_os: 10, span: 175, first_tx: 174};

    rst_in = 1'b1; en = 1'b0; div_load = 1'b0; rx_sync = 1'b0;
    div_int = '0; div_frac = '0;
    step();
    step();
    settle();
    check("rst_os", os_tick, 0);
    check("rst_tx", tx_tick, 0);
    check("rst_rx", rx_tick, 0);
    check("rst_pend", div_pend, 0);
    rst_in = 1'b0;

    // Table: divisor settings against first tick, 16-period span and first tx_tick.
    for (int i = 0; i < 5; i++) begin
      set_div(vecs[i].d, vecs[i].f);
      en = 1'b1; cyc = 0; n = 0; t1 = -1; t17 = -1; ttx = -1;
      while (n < 17 && cyc < 3000) begin
        step();
        settle();
        if (os_tick) begin
          n++;
          if (n == 1) t1 = cyc;
          if (n == 17) t17 = cyc;
        end
        if (tx_tick && ttx < 0) ttx = cyc;
      end
      check("tbl_first_os", t1, vecs[i].first_os);
      check("tbl_span", t17 - t1, vecs[i].span);
      check("tbl_first_tx", ttx, vecs[i].first_tx);
    end

    // Divisor update mid-period, then a double load before a boundary.
    set_div(4, 0);
    en = 1'b1; cyc = 0;
    wait_os(t);
    wait_os(t);
    check("upd_os8", t, 8);
    step();
    div_int = div_int_t'(10); div_load = 1'b1;
    settle();
    step(); settle(); check("upd_pend10", div_pend, 1);
    step(); settle(); check("upd_pend11", div_pend, 1);
    step(); settle();
    check("upd_os12", os_tick, 1);
    check("upd_pend12", div_pend, 0);
    wait_os(t);
    check("upd_period10", t, 22);
    step(); div_int = div_int_t'(6); div_load = 1'b1;
    step(); div_int = div_int_t'(8); div_load = 1'b1;
    wait_os(t);
    check("dbl_old_period", t, 32);
    wait_os(t);
    check("dbl_last_wins", t, 40);

    // rx_sync landing on the os_tick that would have produced rx_tick.
    set_div(4, 0);
    en = 1'b1; cyc = 0;
    for (int c = 1; c <= 140; c++) begin
      step();
      if (cyc == 32) rx_sync = 1'b1;
      settle();
      if (cyc == 32) check("sync_os_coincide", os_tick, 1);
      check("sync_rx_seq", rx_tick, (cyc == 64 || cyc == 128) ? 1 : 0);
    end

    // Clamped divisor, enable drop mid-bit and re-raise.
    set_div(0, 0);
    en = 1'b1; cyc = 0;
    step(); step(); step(); step();
    en = 1'b0;
    settle();
    check("endrop_os4", os_tick, 1);
    for (int c = 5; c <= 9; c++) begin
      step();
      settle();
      check("endrop_quiet", {os_tick, tx_tick, rx_tick}, 0);
    end
    step();
    en = 1'b1; cyc = 0;
    wait_os(t);
    check("enrise_first", t, 2);

    // Randomized runs against an arithmetic model of tick times.
    for (int trial = 0; trial < 6; trial++) begin
      dd = int'($urandom_range(0, 9));
      ff = int'($urandom_range(0, 15));
      set_div(dd, ff);
      if (dd < 2) dd = 2;
      en = 1'b1; cyc = 0; n = 0; rxc = 0;
      for (int c = 1; c <= 300; c++) begin
        step();
        rx_sync = ($urandom_range(0, 19) == 0);
        settle();
        next_t = (n + 1) * dd + (n * ff) / 16;
        exp_os = (cyc == next_t);
        if (exp_os) n++;
        exp_tx = exp_os && (n % 16 == 0);
        if (rx_sync) begin
          rxc = 0;
          exp_rx = 1'b0;
        end else begin
          if (exp_os) rxc++;
          exp_rx = exp_os && (rxc % 16 == 8);
        end
        check("rand_ticks", {os_tick, tx_tick, rx_tick}, {exp_os, exp_tx, exp_rx});
      end
    end

    // Reset mid-run with pending load and strobes.
    set_div(4, 0);
    en = 1'b1;
    step(); step(); step();
    div_int = div_int_t'(7); div_load = 1'b1;
    step();
    rst_in = 1'b1; div_int = div_int_t'(9); div_load = 1'b1; rx_sync = 1'b1;
    step();
    rst_in = 1'b0; cyc = 0;
    settle();
    check("midrst_ticks", {os_tick, tx_tick, rx_tick}, 0);
    check("midrst_pend", div_pend, 0);
    wait_os(t);
    check("midrst_div_os1", t, 325);
    wait_os(t);
    check("midrst_div_os2", t, 650);
    wait_os(t);
    check("midrst_frac_os3", t, 976);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
